// File: rtl/rv32i_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32i_mem_arbiter
//
// Shares one single-port synchronous memory between the RV32I core data port
// and a DMA/loader port. The grant is decided combinationally in the request
// cycle, so the memory is driven in that same cycle. The response (rvalid,
// err, rdata) is returned to the granted port exactly one cycle later. Back-to-
// back grants are supported at one per cycle.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : a conflict without lock goes to the port not granted most
//               recently.
//   undefined : fixed priority. The core wins every conflict unless the DMA
//               holds an active lock.
//   In both builds a locked DMA burst keeps the grant for at most MAX_LOCK
//   consecutive cycles while the core is waiting.
//
// Parameters
//   n        data/address width in bits
//   depth    memory size in n-bit words (AW = $clog2(depth))
//   MAX_LOCK maximum consecutive locked DMA grants
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   core_req/we/addr/wdata          core request (byte address)
//   core_gnt/rvalid/err/rdata       core grant and response
//   dma_req/we/lock/addr/wdata      DMA request, lock = burst lock
//   dma_gnt/rvalid/err/rdata        DMA grant and response
//   mem_en/we/addr/wdata            memory command (word address)
//   mem_rdata                       memory read data, one cycle after mem_en
// ---------------------------------------------------------------------------
module rv32i_mem_arbiter #(
  parameter int n        = 32,
  parameter int depth    = 1024,
  parameter int MAX_LOCK = 8,
  localparam int AW      = $clog2(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [n-1:0]  core_addr,
  input  logic [n-1:0]  core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic          core_err,
  output logic [n-1:0]  core_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_lock,
  input  logic [n-1:0]  dma_addr,
  input  logic [n-1:0]  dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic          dma_err,
  output logic [n-1:0]  dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [n-1:0]  mem_wdata,
  input  logic [n-1:0]  mem_rdata
);

  // The state names the port granted in a cycle. The registered copy tells
  // the response logic which port owns the response in the following cycle.
  typedef enum logic [1:0] {IDLE, CORE, DMA, DMA_LOCK} state_t;

  localparam int            CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);
  localparam logic [n-1:0]  DEPTH_N  = n'(depth);

  state_t        state_q, next_state;
  logic          last_grant;
  logic [CW-1:0] lock_cnt;
  logic          rsp_err_q, rsp_rd_q;
  logic          core_legal, dma_legal, sel_legal;
  logic          lock_hold, core_wins;

  // An address is legal when it is word-aligned and the word index is inside
  // the memory.
  assign core_legal = (core_addr[1:0] == 2'b00) && ({2'b00, core_addr[n-1:2]} < DEPTH_N);
  assign dma_legal  = (dma_addr[1:0] == 2'b00) && ({2'b00, dma_addr[n-1:2]} < DEPTH_N);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  // Arbitration. The DMA keeps the grant only if it was granted under lock in
  // the previous cycle and its budget is not used up. When the budget is
  // exhausted, a waiting core wins in both builds.
  always_comb begin
    next_state = IDLE;
    lock_hold  = dma_req && dma_lock && (state_q == DMA_LOCK) && (lock_cnt < LOCK_MAX);
    core_wins  = core_req;
    if (core_req && dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      core_wins = !lock_hold && last_grant;
`else
      core_wins = !lock_hold;
`endif
    end
    if (reset)          next_state = IDLE;
    else if (core_wins) next_state = CORE;
    else if (dma_req)   next_state = dma_lock ? DMA_LOCK : DMA;
  end

  // Memory command for the winner. An illegal access is still granted, but
  // the memory is not enabled.
  always_comb begin
    core_gnt  = (next_state == CORE);
    dma_gnt   = (next_state == DMA) || (next_state == DMA_LOCK);
    sel_legal = core_gnt ? core_legal : (dma_gnt && dma_legal);
    mem_en    = sel_legal;
    mem_we    = sel_legal && (core_gnt ? core_we : dma_we);
    mem_addr  = core_gnt ? core_addr[AW+1:2] : dma_addr[AW+1:2];
    mem_wdata = core_gnt ? core_wdata : dma_wdata;
  end

  // Fairness history, lock budget, and the pending response kind. The lock
  // counter saturates, so a lone locked DMA cannot wrap it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rsp_err_q  <= 1'b0;
      rsp_rd_q   <= 1'b0;
    end else begin
      if (core_gnt)     last_grant <= 1'b0;
      else if (dma_gnt) last_grant <= 1'b1;
      if (core_gnt || !dma_lock)
        lock_cnt <= '0;
      else if (dma_gnt && (lock_cnt != LOCK_MAX))
        lock_cnt <= lock_cnt + 1'b1;
      rsp_err_q <= (core_gnt || dma_gnt) && !sel_legal;
      rsp_rd_q  <= mem_en && !mem_we;
    end
  end

  // Response path. Read data is passed through from the memory only for a
  // legal read. Every response output is forced low while reset is high.
  always_comb begin
    core_rvalid = !reset && (state_q == CORE);
    dma_rvalid  = !reset && ((state_q == DMA) || (state_q == DMA_LOCK));
    core_err    = core_rvalid && rsp_err_q;
    dma_err     = dma_rvalid && rsp_err_q;
    core_rdata  = (core_rvalid && rsp_rd_q) ? mem_rdata : '0;
    dma_rdata   = (dma_rvalid && rsp_rd_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32i_mem_arbiter
//
// Self-checking bench for rv32i_mem_arbiter.
//
// Expected grants come from a vector table plus hand-written lock and reset
// sequences. Expected responses are computed from a shadow copy of the memory
// contents, pushed into a queue in the grant cycle, and popped and compared in
// the following cycle. Expectations that differ between the two arbitration
// modes follow ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_rv32i_mem_arbiter;

  localparam int N     = 32;
  localparam int DEPTH = 1024;
  localparam int MAXL  = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [N-1:0]  core_addr = '0, core_wdata = '0;
  logic          core_gnt, core_rvalid, core_err;
  logic [N-1:0]  core_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [N-1:0]  dma_addr = '0, dma_wdata = '0;
  logic          dma_gnt, dma_rvalid, dma_err;
  logic [N-1:0]  dma_rdata;
  logic          mem_en, mem_we;
  logic [9:0]    mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.n(N), .depth(DEPTH), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_err(core_err), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
    .dma_rdata(dma_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory model with one cycle of read latency. Word 4 is
  // reloaded with a known pattern on every reset.
  logic [N-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (reset) ram[4] <= 32'hDEADBEEF;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    bit          rst;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        dreq, dwe, dlock;
    logic [31:0] daddr, dwd;
    logic        egc, egd;
  } vec_t;

  typedef struct {
    bit          is_dma;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] shadow [0:DEPTH-1];
  int          n_checks = 0;
  int          n_fails  = 0;

  function automatic vec_t mk(bit rst, logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
                              logic dreq, logic dwe, logic dlock, logic [31:0] daddr,
                              logic [31:0] dwd, logic egc, logic egd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.daddr = daddr; v.dwd = dwd;
    v.egc = egc; v.egd = egd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks the memory command for an expected grant, computes the response
  // from the shadow memory, and queues it for the next cycle.
  task automatic expectGrant(input bit is_dma, input logic we, input logic [31:0] a,
                             input logic [31:0] wd);
    rsp_t e;
    bit   legal;
    legal = (a[1:0] == 2'b00) && (a[31:2] < DEPTH);
    checkOutput("mem_en", {31'b0, mem_en}, {31'b0, legal});
    if (legal) begin
      checkOutput("mem_we", {31'b0, mem_we}, {31'b0, we});
      checkOutput("mem_addr", {22'b0, mem_addr}, {22'b0, a[11:2]});
      if (we) checkOutput("mem_wdata", mem_wdata, wd);
    end
    e.is_dma = is_dma;
    e.err    = !legal;
    e.rdata  = (legal && !we) ? shadow[a[11:2]] : 32'h0;
    if (legal && we) shadow[a[11:2]] = wd;
    rsp_q.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    rsp_t e;
    @(negedge clk);
    reset = v.rst;
    core_req = v.creq; core_we = v.cwe; core_addr = v.caddr; core_wdata = v.cwd;
    dma_req = v.dreq; dma_we = v.dwe; dma_lock = v.dlock; dma_addr = v.daddr; dma_wdata = v.dwd;
    #1;
    if (v.rst) begin
      rsp_q.delete();
      shadow[4] = 32'hDEADBEEF;
      checkOutput("rst_ctrl", {24'b0, core_gnt, dma_gnt, core_rvalid, dma_rvalid,
                               core_err, dma_err, mem_en, mem_we}, 32'h0);
      checkOutput("rst_core_rdata", core_rdata, 32'h0);
      checkOutput("rst_dma_rdata", dma_rdata, 32'h0);
    end else begin
      if (rsp_q.size() != 0) begin
        e = rsp_q.pop_front();
        checkOutput("rvalid", {30'b0, core_rvalid, dma_rvalid}, e.is_dma ? 32'h1 : 32'h2);
        checkOutput("rsp_err", {31'b0, e.is_dma ? dma_err : core_err}, {31'b0, e.err});
        checkOutput("rsp_rdata", e.is_dma ? dma_rdata : core_rdata, e.rdata);
      end else begin
        checkOutput("no_rvalid", {30'b0, core_rvalid, dma_rvalid}, 32'h0);
      end
      checkOutput("core_gnt", {31'b0, core_gnt}, {31'b0, v.egc});
      checkOutput("dma_gnt", {31'b0, dma_gnt}, {31'b0, v.egd});
      if (v.egc)      expectGrant(1'b0, v.cwe, v.caddr, v.cwd);
      else if (v.egd) expectGrant(1'b1, v.dwe, v.daddr, v.dwd);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // Directed table: rst creq cwe caddr cwd  dreq dwe dlock daddr dwd  egc egd
    tbl.push_back(mk(1, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h20, 32'hA5A50001, 0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h2, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h1000, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h1004, 32'h55, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, !RR, RR));
    tbl.push_back(mk(0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, !RR, RR));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h30, 32'h1111, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h30, 32'h2222, 0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h30, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h30, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Locked DMA burst against a waiting core: 8 DMA grants, then the core.
    $display("[TB] lock sequence");
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h20, 0, 0, 1));
    for (int k = 0; k < MAXL - 1; k++)
      applyStimulus(mk(0, 1, 0, 32'h10, 0, 1, 0, 1, 32'h20, 0, 0, 1));
    applyStimulus(mk(0, 1, 0, 32'h10, 0, 1, 0, 1, 32'h20, 0, 1, 0));
    applyStimulus(mk(0, 1, 0, 32'h10, 0, 1, 0, 1, 32'h20, 0, !RR, RR));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset right after a DMA grant drops its response. The first conflict
    // after reset goes to the core.
    $display("[TB] reset after grant sequence");
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0, 0, 1));
    applyStimulus(mk(1, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 0, 0));
    applyStimulus(mk(0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 1, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 Parameter n, default 32, data and address width in bits.
REQ-002 Parameter depth, default 1024, memory size in n-bit words; AW = $clog2(depth).
REQ-003 Parameter MAX_LOCK, default 8, maximum number of consecutive DMA grants under lock.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 core_req, core_we  in  1 each  core data-port request and write enable.
REQ-008 core_addr, core_wdata  in  n each  core byte address and write data.
REQ-009 core_gnt, core_rvalid, core_err  out  1 each  grant, response valid, response error.
REQ-010 core_rdata  out  n  core read data.
REQ-011 dma_req, dma_we, dma_lock  in  1 each  DMA/loader request, write enable, burst lock.
REQ-012 dma_addr, dma_wdata  in  n each  DMA byte address and write data.
REQ-013 dma_gnt, dma_rvalid, dma_err  out  1 each; dma_rdata  out  n.
REQ-014 mem_en, mem_we  out  1 each; mem_addr  out  AW  word address; mem_wdata  out  n.
REQ-015 mem_rdata  in  n  read data from the single-port memory, valid one cycle after mem_en.

Function
REQ-016 Grant SHALL be combinational within the cycle: at most one of core_gnt/dma_gnt is high, and only for an asserted req.
REQ-017 A granted request is accepted on that rising edge; the requester SHALL hold req/addr/wdata stable until it sees gnt.
REQ-018 Address check: legal iff addr[1:0]==0 and addr[n-1:2] < depth; mem_addr = addr[AW+1:2].
REQ-019 Legal granted access: mem_en=1, mem_we=req_we, mem_wdata=wdata in the grant cycle; otherwise mem_en=0, mem_we=0.
REQ-020 Illegal granted access: still granted, mem_en=0, response carries err=1 and rdata=0.
REQ-021 Response: exactly one cycle after the grant, the granted port's rvalid=1 for one cycle; rdata=mem_rdata for a legal read, 0 for a write or illegal access; err as per REQ-020.
REQ-022 Back-to-back grants SHALL be sustained at one per cycle, with a response every cycle.
REQ-023 FSM states: IDLE (no grant), CORE (core granted this cycle), DMA (DMA granted), DMA_LOCK (DMA granted under lock).
REQ-024 Arbitration with both requesting and no lock: the port not granted most recently (last_grant register) wins.
REQ-025 Lock: while dma_lock=1 and DMA is granted, DMA keeps the grant every cycle it requests; a lock counter increments per locked grant.
REQ-026 When the lock counter reaches MAX_LOCK and core_req=1, core SHALL be granted next; the counter clears on any core grant or when dma_lock=0.
REQ-027 A lone requester SHALL always be granted immediately, whatever last_grant holds.
REQ-028 Writes to the same word in consecutive cycles from different ports SHALL be applied in grant order.

Reset
REQ-029 When reset=1 at an edge: state=IDLE, last_grant=DMA (core wins the first conflict), lock counter=0, pending response cleared.
REQ-030 While reset is asserted, all gnt, rvalid, err, mem_en and mem_we outputs SHALL be 0; rdata outputs SHALL be 0.
REQ-031 A response owed from the cycle before reset SHALL be dropped (no rvalid after reset).

Configuration
REQ-032 Macro ARB_ROUND_ROBIN_EN defined: arbitration per REQ-024.
REQ-033 ARB_ROUND_ROBIN_EN undefined: fixed priority, core always wins a conflict; DMA lock (REQ-025/026) still applies, and it is the only way DMA wins a conflict.

Verification
REQ-034 Core read of addr 0x10 holding 0xDEADBEEF -> core_gnt same cycle, mem_addr=4, next cycle core_rvalid=1, core_rdata=0xDEADBEEF, core_err=0.
REQ-035 Both req every cycle, no lock, RR enabled -> grants alternate core, DMA, core, ... starting with core after reset.
REQ-036 DMA lock with MAX_LOCK=8 and core_req held -> 8 consecutive dma_gnt, then core_gnt on the 9th cycle.
REQ-037 Core read at addr 0x2 or at addr 0x1000 (depth=1024) -> gnt, mem_en=0, next cycle core_rvalid=1, core_err=1, core_rdata=0.
REQ-038 Reset asserted the cycle after a DMA grant -> no dma_rvalid, all outputs 0, first post-reset conflict granted to core.
REQ-039 Macro undefined, both req, no lock -> core granted every cycle, DMA never granted.
